// File: rtl/fsm_lcd_ctrl_if.sv
// fsm_lcd_ctrl_if: start request, datapath comparator flags and command strobes
// exchanged between the LCD control FSM and its surroundings.
interface fsm_lcd_ctrl_if;
  logic start;
  logic C1;
  logic C2;
  logic C3;
  logic C4;
  logic C5;
  logic ADD1;
  logic ADD2;
  logic LOAD1;
  logic LOAD2;
  logic LOAD3;
  logic LOAD4;
  logic RESET1;
  logic RESET2;
  logic DONE;
  logic busy;

  modport master (
    output start, C1, C2, C3, C4, C5,
    input  ADD1, ADD2, LOAD1, LOAD2, LOAD3, LOAD4, RESET1, RESET2, DONE, busy
  );

  modport slave (
    input  start, C1, C2, C3, C4, C5,
    output ADD1, ADD2, LOAD1, LOAD2, LOAD3, LOAD4, RESET1, RESET2, DONE, busy
  );
endinterface

// File: rtl/fsm_lcd_ctrl.sv
// fsm_lcd_ctrl: Moore sequencer driving datapath_LCD through one LCD write program.
// Define LCD_POWERON_WAIT_EN to build the 2 ms power-on wait (PWR/PWR_CLR states).
module fsm_lcd_ctrl (
  input  logic          clk,
  input  logic          rst_n,
  fsm_lcd_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE,
`ifdef LCD_POWERON_WAIT_EN
    PWR,
    PWR_CLR,
`endif
    FETCH,
    DRIVE,
    TAS,
    EHI,
    PW,
    ELO,
    CYC,
    NEXT,
    CHECK,
    FIN
  } state_t;

  typedef struct packed {
    logic add1;
    logic add2;
    logic load1;
    logic load2;
    logic load3;
    logic load4;
    logic reset1;
    logic reset2;
    logic done;
    logic busy;
  } strobes_t;

  state_t   state_reg;
  state_t   state_next;
  strobes_t out_reg;

  // Outputs depend on state only; registering decode(next) keeps them glitch-free.
  function automatic strobes_t decode(input state_t s);
    strobes_t o;
    o      = '0;
    o.busy = (s != IDLE) && (s != FIN);
    case (s)
      IDLE:    begin o.reset1 = 1'b1; o.reset2 = 1'b1; end
`ifdef LCD_POWERON_WAIT_EN
      PWR:     o.add1   = 1'b1;
      PWR_CLR: o.reset1 = 1'b1;
`endif
      FETCH:   o.load1  = 1'b1;
      DRIVE:   begin o.load2 = 1'b1; o.add1 = 1'b1; end
      TAS:     o.add1   = 1'b1;
      EHI:     begin o.load3 = 1'b1; o.add1 = 1'b1; end
      PW:      o.add1   = 1'b1;
      ELO:     begin o.load4 = 1'b1; o.add1 = 1'b1; end
      CYC:     o.add1   = 1'b1;
      NEXT:    begin o.add2 = 1'b1; o.reset1 = 1'b1; end
      FIN:     o.done   = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          if (bus.C4) begin
            state_next = FIN;
          end else begin
`ifdef LCD_POWERON_WAIT_EN
            state_next = PWR;
`else
            state_next = FETCH;
`endif
          end
        end
      end
`ifdef LCD_POWERON_WAIT_EN
      PWR:     if (bus.C3) state_next = PWR_CLR;
      PWR_CLR: state_next = FETCH;
`endif
      FETCH:   state_next = DRIVE;
      DRIVE:   state_next = TAS;
      // Wait states keep ADD1 high and watch for the one-cycle equality pulse.
      TAS:     if (bus.C5) state_next = EHI;
      EHI:     state_next = PW;
      PW:      if (bus.C1) state_next = ELO;
      ELO:     state_next = CYC;
      CYC:     if (bus.C2) state_next = NEXT;
      NEXT:    state_next = CHECK;
      CHECK:   state_next = bus.C4 ? FIN : FETCH;
      FIN:     if (!bus.start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      out_reg   <= decode(IDLE);
    end else begin
      state_reg <= state_next;
      out_reg   <= decode(state_next);
    end
  end

`ifndef LCD_POWERON_WAIT_EN
  logic c3_unused;
  assign c3_unused = bus.C3;
`endif

  assign bus.ADD1   = out_reg.add1;
  assign bus.ADD2   = out_reg.add2;
  assign bus.LOAD1  = out_reg.load1;
  assign bus.LOAD2  = out_reg.load2;
  assign bus.LOAD3  = out_reg.load3;
  assign bus.LOAD4  = out_reg.load4;
  assign bus.RESET1 = out_reg.reset1;
  assign bus.RESET2 = out_reg.reset2;
  assign bus.DONE   = out_reg.done;
  assign bus.busy   = out_reg.busy;

endmodule

// File: doc/fsm_lcd_ctrl.md
# fsm_lcd_ctrl

Control FSM that sequences `datapath_LCD` through one full LCD write program: power-on wait, then per instruction fetch, bus drive, E-pulse generation and cycle-time wait, until the instruction count matches `numeroInstrucciones`. It consumes the datapath comparator flags `C1`–`C5` and drives its command strobes. It sits between the bicycle-rack application logic, which issues `start`, and the datapath.

## Interface
Parameters: none. Time thresholds live in the datapath comparators: 10 ns per `ADD1` cycle at 100 MHz.

- `clk`  in  1  system clock, 100 MHz; FSM updates on posedge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  level request to run the program
- `C1`  in  1  nano counter == 200; E pulse width reached
- `C2`  in  1  nano counter == 1000; instruction cycle time reached
- `C3`  in  1  nano counter == 2000000; power-on wait reached
- `C4`  in  1  instruction counter == `numeroInstrucciones`
- `C5`  in  1  nano counter == 30; address setup reached
- `ADD1`  out  1  increment nano counter
- `ADD2`  out  1  increment instruction counter
- `LOAD1`  out  1  fetch current instruction
- `LOAD2`  out  1  drive DB7..DB0, R/W, RS
- `LOAD3`  out  1  drive E from the instruction
- `LOAD4`  out  1  force E = 0
- `RESET1`  out  1  clear nano counter
- `RESET2`  out  1  clear instruction counter and `salida`
- `DONE`  out  1  program complete
- `busy`  out  1  high in every state except IDLE and FIN

## Operation
- Moore FSM with registered state. Every output is decoded from state only and is 0 unless listed for that state.
- IDLE: `RESET1`=`RESET2`=1.
  - `start`=1 and `C4`=1 → FIN (empty program).
  - Otherwise `start`=1 → PWR, or → FETCH when the power-on wait is compiled out.
- PWR: `ADD1`. On `C3` → PWR_CLR.
- PWR_CLR: `RESET1`. → FETCH.
- FETCH: `LOAD1`. → DRIVE.
- DRIVE: `LOAD2`, `ADD1`. → TAS.
- TAS: `ADD1`. On `C5` → EHI.
- EHI: `LOAD3`, `ADD1`. → PW.
- PW: `ADD1`. On `C1` → ELO.
- ELO: `LOAD4`, `ADD1`. → CYC.
- CYC: `ADD1`. On `C2` → NEXT.
- NEXT: `ADD2`, `RESET1`. → CHECK.
- CHECK: no strobes. `C4`=1 → FIN, else → FETCH.
- FIN: `DONE`=1. `start`=0 → IDLE. Leaving FIN clears `salida` through `RESET2` in IDLE.
- `start` is ignored outside IDLE and FIN; deasserting it mid-program does not abort.
- C-flags are equality pulses, high for exactly one cycle. Wait states must sample them every cycle and never hold the counter (`ADD1` stays high through each wait).
- `C4` is only acted on in IDLE and CHECK.

## Timing
- Reset values: `RESET1`=1, `RESET2`=1; all other outputs 0; state IDLE.
- Asserting `rst_n` mid-program forces IDLE immediately, asynchronously. The datapath is cleared on the next negedge through `RESET1`/`RESET2`.
- The datapath acts on negedge, so a strobe asserted at posedge N is applied at the negedge of cycle N. The flag it produces is seen by the FSM at posedge N+1.
- Per-instruction window, with nano counting from 0 entering DRIVE:
  - E rises at count 40 (EHI).
  - E falls at count 210–220 (ELO).
  - NEXT follows the cycle where `C2` is seen.
  - Instruction period is 104 clk ± 1.
- Power-on: PWR holds for 200000 cycles, plus one cycle for PWR_CLR.
- `DONE` rises 1 cycle after the CHECK in which `C4`=1.
- Counter widths and wrap are the datapath's; the FSM adds no arithmetic.

## Configuration
- `LCD_POWERON_WAIT_EN` defined: IDLE → PWR, giving a 2 ms wait before the first instruction (HD44780 power-up).
- Undefined: PWR and PWR_CLR are not built. IDLE → FETCH directly, and `C3` is unused.

## Test plan
- Reset: `rst_n`=0 → `RESET1`=`RESET2`=1, `DONE`=`busy`=0, all `LOAD*`/`ADD*`=0.
- Empty program: `numeroInstrucciones`=0, `start`=1 → `DONE`=1 after 1 cycle, no `LOAD1` ever.
- Program of 3 instructions, macro off, with the datapath model → exactly 3 `LOAD1` pulses and 3 `ADD2` pulses; E high 17–18 cycles per instruction; `DONE` after about 312 cycles.
- Macro on, 1 instruction → first `LOAD1` at least 200001 cycles after `start`.
- Reset mid-PW (E high), then release and `start` again → restarts from instruction 0; `salida` returns to 0 first.
- Hold `start`=1 through FIN → `DONE` stays 1. Drop `start` → IDLE next cycle with `DONE`=0; re-raise `start` → reruns the program.
